mem_wb_ctrl: RTL
================

# mem_wb_ctrl

Memory-access and writeback sequencer placed between execute and the register-file write port. It decodes load/store operations, drives a single-port word-wide data memory with no byte enables (read-modify-write for sub-word stores), and produces the registered writeback triple (enable, destination, data). It stalls upstream for multi-cycle operations. Non-memory results pass through with one-cycle latency.

## Interface
- No parameters; data width fixed at 32, register index 5 bits.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation presented this cycle
- in_load  in  1  load op; wins over in_store if both set
- in_store  in  1  store op
- in_funct3  in  3  size: 000 B, 001 H, 010 W, 100 BU, 101 HU
- in_we  in  1  operation writes rd
- in_rd  in  5  destination register
- in_alu  in  32  ALU result or effective address
- in_sdata  in  32  store data
- stall  out  1  combinational; upstream holds all in_* stable while high
- mem_req  out  1  memory access this cycle (combinational from state)
- mem_we  out  1  1 write, 0 read
- mem_addr  out  32  word address, bits [1:0] always 0
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid the cycle after a read request
- wb_en  out  1  registered writeback enable
- wb_rd  out  5  registered destination
- wb_data  out  32  registered writeback data
- mem_fault  out  1  registered one-cycle pulse: misaligned/illegal access

## Operation
- States: IDLE, LD_REQ, LD_DATA, ST_WR, RMW_RD, RMW_WR.
- Op accepted at the edge where in_valid=1 and stall=0; request fields (rd, we, funct3, address, sdata) latched on leaving IDLE.
- IDLE, in_valid=0: wb_en<=0.
- IDLE, non-memory op: stall=0; wb_en<=in_we&(in_rd!=0), wb_rd<=in_rd, wb_data<=in_alu.
- Fault check in IDLE: H/HU with addr[0]=1, W with addr[1:0]!=0, or funct3 011/110/111 (loads), or funct3 other than 000/001/010 (stores) -> stall=0, no memory access, wb_en<=0, mem_fault<=1 for one cycle.
- Load: IDLE (stall=1) -> LD_REQ (mem_req=1, mem_we=0, stall=1) -> LD_DATA (stall=0, wb regs loaded from mem_rdata) -> IDLE.
- Load extraction, little-endian: byte = rdata[8*a[1:0]+:8], half = rdata[16*a[1]+:16]; B/H sign-extend, BU/HU zero-extend, W as is. wb_en = latched we & rd!=0.
- Store W: IDLE (stall=1) -> ST_WR (mem_req=1, mem_we=1, mem_wdata=sdata, stall=0) -> IDLE.
- Store B/H: IDLE (stall=1) -> RMW_RD (read, stall=1) -> RMW_WR (write merged word: mem_rdata with selected lane replaced by sdata[7:0] or sdata[15:0]; stall=0) -> IDLE.
- Stores never write back: wb_en<=0 at completion and during busy cycles.
- wb_en=0 on every edge where no writeback completes; wb_rd/wb_data hold last value.
- mem_addr = {latched_addr[31:2],2'b00} whenever mem_req=1, else 0; mem_we/mem_wdata 0 when mem_req=0.

## Timing
- Reset: state IDLE; wb_en=0, wb_rd=0, wb_data=0, mem_fault=0; mem_req/mem_we/mem_addr/mem_wdata 0 immediately (combinational from state).
- Reset mid-operation aborts it; a half-done RMW leaves memory untouched if asserted before RMW_WR.
- Occupancy per op: non-memory/fault 1 cycle, store W 2, load 3, store B/H 3.
- Load result on wb_* the cycle after LD_DATA (3 edges after presentation).
- Back-to-back ops: next op may be presented in the cycle following acceptance; no idle bubble required.
- stall is low exactly in the accept cycle of each op; never high in IDLE for non-memory/fault ops.

## Test plan
- Reset then ALU op in_we=1 rd=5 alu=0x1234_5678 -> next cycle wb_en=1 wb_rd=5 wb_data=0x1234_5678, stall never high.
- LB addr 0x103, memory word 0x8000_0000 -> mem_addr=0x100 in LD_REQ; wb_data=0xFFFF_FF80; LBU same -> 0x0000_0080; stall high 2 cycles.
- SB sdata=0xAB addr 0x201, word 0x1122_3344 -> read 0x200 then write 0x1122_AB44; wb_en stays 0.
- SW addr 0x204 sdata=0xDEAD_BEEF -> single write cycle, stall high 1 cycle; LW addr 0x206 -> mem_fault pulse, mem_req never asserted, wb_en=0.
- Load with rd=0 -> memory read occurs, wb_en=0; back-to-back LW, ALU op, SH each complete with correct occupancy.
- rst_n low during RMW_RD -> mem_req drops same cycle, no write issued, outputs at reset values.

Source files
------------

// File: rtl/mem_wb_ctrl.sv
`default_nettype none
// =============================================================================
// mem_wb_ctrl : load/store memory sequencer and registered writeback stage
// Revision    : 1.0  initial release
// =============================================================================
module mem_wb_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic        in_load,
   input  logic        in_store,
   input  logic [2:0]  in_funct3,
   input  logic        in_we,
   input  logic [4:0]  in_rd,
   input  logic [31:0] in_alu,
   input  logic [31:0] in_sdata,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        wb_en,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        mem_fault
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LD_REQ  = 3'd1,
      LD_DATA = 3'd2,
      ST_WR   = 3'd3,
      RMW_RD  = 3'd4,
      RMW_WR  = 3'd5
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   state_t      state_q, state_d;
   logic [4:0]  rd_q, rd_d;
   logic        we_q, we_d;
   logic [2:0]  f3_q, f3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] sdata_q, sdata_d;
   logic        wb_en_q, wb_en_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        mem_fault_q, mem_fault_d;

   logic        is_load;
   logic        is_store;
   logic        acc_illegal;
   logic        acc_misalign;
   logic        acc_fault;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_value;
   logic [31:0] merged;

   // Load takes priority when both op flags are raised.
   assign is_load  = in_load;
   assign is_store = in_store & ~in_load;

   always_comb begin
      acc_illegal  = 1'b0;
      acc_misalign = 1'b0;
      case (in_funct3)
         F3_B:    acc_misalign = 1'b0;
         F3_H:    acc_misalign = in_alu[0];
         F3_W:    acc_misalign = |in_alu[1:0];
         F3_BU:   acc_illegal  = is_store;
         F3_HU: begin
            acc_illegal  = is_store;
            acc_misalign = in_alu[0];
         end
         default: acc_illegal  = 1'b1;
      endcase
      acc_fault = (is_load | is_store) & (acc_illegal | acc_misalign);
   end

   // Little-endian lane extraction of the returned word.
   always_comb begin
      case (addr_q[1:0])
         2'd0:    ld_byte = mem_rdata[7:0];
         2'd1:    ld_byte = mem_rdata[15:8];
         2'd2:    ld_byte = mem_rdata[23:16];
         default: ld_byte = mem_rdata[31:24];
      endcase
      ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (f3_q)
         F3_B:    ld_value = {{24{ld_byte[7]}}, ld_byte};
         F3_BU:   ld_value = {24'h0, ld_byte};
         F3_H:    ld_value = {{16{ld_half[15]}}, ld_half};
         F3_HU:   ld_value = {16'h0, ld_half};
         default: ld_value = mem_rdata;
      endcase
   end

   // Sub-word store: old word from the RMW read with one lane replaced.
   always_comb begin
      merged = mem_rdata;
      if (f3_q == F3_H) begin
         if (addr_q[1]) merged[31:16] = sdata_q[15:0];
         else           merged[15:0]  = sdata_q[15:0];
      end else begin
         case (addr_q[1:0])
            2'd0:    merged[7:0]   = sdata_q[7:0];
            2'd1:    merged[15:8]  = sdata_q[7:0];
            2'd2:    merged[23:16] = sdata_q[7:0];
            default: merged[31:24] = sdata_q[7:0];
         endcase
      end
   end

   always_comb begin
      state_d     = state_q;
      rd_d        = rd_q;
      we_d        = we_q;
      f3_d        = f3_q;
      addr_d      = addr_q;
      sdata_d     = sdata_q;
      wb_en_d     = 1'b0;
      wb_rd_d     = wb_rd_q;
      wb_data_d   = wb_data_q;
      mem_fault_d = 1'b0;
      stall       = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_wdata   = 32'h0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (acc_fault) begin
                  mem_fault_d = 1'b1;
               end else if (is_load | is_store) begin
                  stall   = 1'b1;
                  rd_d    = in_rd;
                  we_d    = in_we;
                  f3_d    = in_funct3;
                  addr_d  = in_alu;
                  sdata_d = in_sdata;
                  if (is_load)                state_d = LD_REQ;
                  else if (in_funct3 == F3_W) state_d = ST_WR;
                  else                        state_d = RMW_RD;
               end else begin
                  wb_en_d   = in_we & (in_rd != 5'd0);
                  wb_rd_d   = in_rd;
                  wb_data_d = in_alu;
               end
            end
         end
         LD_REQ: begin
            stall   = 1'b1;
            mem_req = 1'b1;
            state_d = LD_DATA;
         end
         LD_DATA: begin
            wb_en_d   = we_q & (rd_q != 5'd0);
            wb_rd_d   = rd_q;
            wb_data_d = ld_value;
            state_d   = IDLE;
         end
         ST_WR: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_wdata = sdata_q;
            state_d   = IDLE;
         end
         RMW_RD: begin
            stall   = 1'b1;
            mem_req = 1'b1;
            state_d = RMW_WR;
         end
         RMW_WR: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_wdata = merged;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_addr = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rd_q        <= 5'd0;
         we_q        <= 1'b0;
         f3_q        <= 3'd0;
         addr_q      <= 32'h0;
         sdata_q     <= 32'h0;
         wb_en_q     <= 1'b0;
         wb_rd_q     <= 5'd0;
         wb_data_q   <= 32'h0;
         mem_fault_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_q        <= rd_d;
         we_q        <= we_d;
         f3_q        <= f3_d;
         addr_q      <= addr_d;
         sdata_q     <= sdata_d;
         wb_en_q     <= wb_en_d;
         wb_rd_q     <= wb_rd_d;
         wb_data_q   <= wb_data_d;
         mem_fault_q <= mem_fault_d;
      end
   end

   assign wb_en     = wb_en_q;
   assign wb_rd     = wb_rd_q;
   assign wb_data   = wb_data_q;
   assign mem_fault = mem_fault_q;

endmodule
`default_nettype wire
